// File: rtl/eth_tx_sched.sv
// Two-source round-robin transmit scheduler for the RGMII byte stream.
// Adds preamble/SFD, forwards the granted payload unchanged, then holds off for the inter-frame gap.
`timescale 1ns/1ps
module eth_tx_sched #(
  parameter int PRE_LEN   = 7,
  parameter int IFG_BYTES = 12,
  parameter int MAX_BYTES = 1518
) (
  input  logic       rgmii_clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       rd,
  input  logic [7:0] din0,
  input  logic [7:0] din1,
  input  logic       last0,
  input  logic       last1,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       overrun
);

  localparam int CNT_A   = (MAX_BYTES > PRE_LEN) ? MAX_BYTES : PRE_LEN;
  localparam int CNT_MAX = (CNT_A > IFG_BYTES) ? CNT_A : IFG_BYTES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, IFG} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_src;
  logic          pick_src1;
  logic [7:0]    sel_din;
  logic          sel_last;

  assign rd       = (state == DATA);
  assign busy     = (state != IDLE);
  assign sel_din  = gnt[1] ? din1 : din0;
  assign sel_last = gnt[1] ? last1 : last0;
  // last_src remembers who was served last, so a tie goes to the other source
  assign pick_src1 = req[1] & (~req[0] | ~last_src);

  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      gnt      <= 2'b00;
      last_src <= 1'b1;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      overrun  <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      overrun  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (|req) begin
            state <= PRE;
            if (pick_src1) begin
              gnt      <= 2'b10;
              last_src <= 1'b1;
            end else begin
              gnt      <= 2'b01;
              last_src <= 1'b0;
            end
          end
        end
        PRE: begin
          tx_valid <= 1'b1;
          tx_data  <= 8'h55;
          if (cnt == CW'(PRE_LEN - 1)) begin
            cnt   <= '0;
            state <= SFD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SFD: begin
          tx_valid <= 1'b1;
          tx_data  <= 8'hD5;
          cnt      <= '0;
          state    <= DATA;
        end
        DATA: begin
          tx_valid <= 1'b1;
          tx_data  <= sel_din;
          // A genuine last byte wins over truncation when both land on the same byte
          if (sel_last) begin
            gnt   <= 2'b00;
            cnt   <= '0;
            state <= IFG;
          end else if (cnt == CW'(MAX_BYTES - 1)) begin
            overrun <= 1'b1;
            gnt     <= 2'b00;
            cnt     <= '0;
            state   <= IFG;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        IFG: begin
          if (cnt == CW'(IFG_BYTES - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_sched.sv
// Bench for eth_tx_sched: frame-level reference model of two requesters and the wire,
// hand-derived table vectors, and a few multi-cycle sequences (IFG wait, mid-frame reset, round-robin).
`timescale 1ns/1ps
module tb_eth_tx_sched;

  localparam int PRE_LEN   = 7;
  localparam int IFG_BYTES = 12;
  localparam int MAX_BYTES = 16;
  localparam int NSLOT     = 128;

  logic       rgmii_clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       rd;
  logic [7:0] din0, din1;
  logic       last0, last1;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       busy;
  logic       overrun;

  typedef struct {int len; logic [7:0] base;} frame_t;
  typedef struct {int src; int len; logic [7:0] base; bit b2b;} exp_t;
  typedef struct {int src; int len; logic [7:0] base; int exp_wire; int exp_rd; int exp_ovr;} vec_t;

  frame_t fr[2][NSLOT];
  int     head[2] = '{0, 0};
  int     tail[2] = '{0, 0};
  int     idx[2]  = '{0, 0};
  int     plan_pos[2] = '{0, 0};
  exp_t   exp_q[$];
  int     mdl_last = 1;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;

  bit         in_frame = 0;
  logic [7:0] obs[$];
  int         start_cyc = 0, low_run = 0, cur_gap = 0;
  int         gnt_cyc = 0, rd_cyc = 0, ovr_cyc = 0;
  int         frame_src = -1, frame_count = 0;
  bit         have_prev = 0;
  int         prev_start = 0, prev_n = 0;
  int         last_wire = 0, last_rd = 0, last_ovr = 0, last_src = -1, last_start = 0, last_gap = 0;
  int         src_log[$];
  bit         rd_prev = 0;
  logic [1:0] gnt_prev = 2'b00;

  eth_tx_sched #(
    .PRE_LEN(PRE_LEN), .IFG_BYTES(IFG_BYTES), .MAX_BYTES(MAX_BYTES)
  ) dut (
    .rgmii_clk(rgmii_clk), .rst(rst), .req(req), .gnt(gnt), .rd(rd),
    .din0(din0), .din1(din1), .last0(last0), .last1(last1),
    .tx_valid(tx_valid), .tx_data(tx_data), .busy(busy), .overrun(overrun)
  );

  always #4 rgmii_clk = ~rgmii_clk;
  always @(posedge rgmii_clk) cyc <= cyc + 1;

  always @(negedge rgmii_clk) begin
    monitor_step();
    drive_sources();
  end

  task automatic cmp(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      errs++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [7:0] cur_byte(input int s);
    if (head[s] == tail[s]) return 8'h00;
    return fr[s][head[s]].base + 8'(idx[s]);
  endfunction

  function automatic logic cur_last(input int s);
    if (head[s] == tail[s]) return 1'b0;
    return (idx[s] == fr[s][head[s]].len - 1);
  endfunction

  // Requesters: hold req while a frame is queued, advance on each pull, drop the frame when gnt falls
  task automatic drive_sources();
    for (int s = 0; s < 2; s++) begin
      if (head[s] != tail[s]) begin
        if (rd_prev && gnt_prev[s]) idx[s]++;
        if (gnt_prev[s] && !gnt[s]) begin
          head[s]++;
          idx[s] = 0;
        end
      end
    end
    rd_prev  = rd;
    gnt_prev = gnt;
    din0  = cur_byte(0);
    din1  = cur_byte(1);
    last0 = cur_last(0);
    last1 = cur_last(1);
    req   = {head[1] != tail[1], head[0] != tail[0]};
  endtask

  task automatic load_frame(input int s, input int len, input logic [7:0] base);
    fr[s][tail[s]] = '{len, base};
    tail[s]++;
  endtask

  // Reference: frames queued together are served alternately, tie goes to the source not served last
  task automatic plan_batch();
    bit first = 1;
    int s;
    while (plan_pos[0] < tail[0] || plan_pos[1] < tail[1]) begin
      if (plan_pos[0] < tail[0] && plan_pos[1] < tail[1]) s = (mdl_last == 0) ? 1 : 0;
      else s = (plan_pos[0] < tail[0]) ? 0 : 1;
      exp_q.push_back('{s, fr[s][plan_pos[s]].len, fr[s][plan_pos[s]].base, !first});
      plan_pos[s]++;
      mdl_last = s;
      first = 0;
    end
  endtask

  task automatic finish_frame();
    exp_t e;
    int n, bad;
    logic [7:0] eb;
    frame_count++;
    last_wire = obs.size(); last_rd = rd_cyc; last_ovr = ovr_cyc;
    last_src = frame_src; last_start = start_cyc; last_gap = cur_gap;
    src_log.push_back(frame_src);
    if (exp_q.size() == 0) begin
      cmp("unexpected_frame", 1, 0);
    end else begin
      e = exp_q.pop_front();
      n = (e.len > MAX_BYTES) ? MAX_BYTES : e.len;
      cmp("frame_src", frame_src, e.src);
      cmp("wire_len", obs.size(), PRE_LEN + 1 + n);
      bad = -1;
      for (int i = 0; i < obs.size() && i < PRE_LEN + 1 + n; i++) begin
        if (i < PRE_LEN) eb = 8'h55;
        else if (i == PRE_LEN) eb = 8'hD5;
        else eb = e.base + 8'(i - PRE_LEN - 1);
        if (obs[i] !== eb && bad < 0) bad = i;
      end
      cmp("wire_first_bad_byte_index", bad, -1);
      cmp("rd_cycles", rd_cyc, n);
      cmp("gnt_cycles", gnt_cyc, PRE_LEN + 1 + n);
      cmp("overrun_pulses", ovr_cyc, (e.len > MAX_BYTES) ? 1 : 0);
      if (have_prev) begin
        if (e.b2b) cmp("frame_spacing", start_cyc - prev_start, PRE_LEN + 1 + prev_n + IFG_BYTES + 1);
        else cmp("ifg_min_met", (cur_gap >= IFG_BYTES) ? 1 : 0, 1);
      end
      prev_start = start_cyc;
      prev_n     = n;
      have_prev  = 1;
    end
    gnt_cyc = 0; rd_cyc = 0; ovr_cyc = 0;
  endtask

  task automatic monitor_step();
    if (rst) begin
      if (in_frame && exp_q.size() > 0) exp_q.delete(0);
      in_frame = 0; obs.delete();
      gnt_cyc = 0; rd_cyc = 0; ovr_cyc = 0; low_run = 0; have_prev = 0;
      return;
    end
    if (rd) cmp("rd_implies_gnt", (gnt != 2'b00) ? 1 : 0, 1);
    if (overrun) cmp("overrun_with_gnt_low", int'(gnt), 0);
    if (gnt != 2'b00) gnt_cyc++;
    if (rd) rd_cyc++;
    if (overrun) ovr_cyc++;
    if (tx_valid) begin
      if (!in_frame) begin
        in_frame  = 1;
        start_cyc = cyc;
        cur_gap   = low_run;
        frame_src = (gnt == 2'b10) ? 1 : (gnt == 2'b01) ? 0 : -1;
        obs.delete();
      end
      obs.push_back(tx_data);
      low_run = 0;
    end else begin
      if (tx_data != 8'h00) cmp("idle_data_zero", int'(tx_data), 0);
      low_run++;
      if (in_frame) begin
        in_frame = 0;
        finish_frame();
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (!(head[0] == tail[0] && head[1] == tail[1] && !busy && !in_frame) && n < bound) begin
      @(posedge rgmii_clk); #1;
      n++;
    end
    if (n >= bound) cmp("idle_timeout", 1, 0);
    repeat (2) @(posedge rgmii_clk);
    #1;
    cmp("expected_frames_left", exp_q.size(), 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    load_frame(v.src, v.len, v.base);
    plan_batch();
    wait_idle(400);
  endtask

  task automatic checkOutput(input vec_t v);
    cmp("tbl_src", last_src, v.src);
    cmp("tbl_wire_bytes", last_wire, v.exp_wire);
    cmp("tbl_rd_cycles", last_rd, v.exp_rd);
    cmp("tbl_overrun", last_ovr, v.exp_ovr);
  endtask

  initial begin
    vec_t tbl[6];
    int   s1, n0, fc, k, guard;

    tbl[0] = '{0, 4,  8'hA1, 12, 4,  0};
    tbl[1] = '{1, 1,  8'h3C, 9,  1,  0};
    tbl[2] = '{1, 40, 8'h10, 24, 16, 1};
    tbl[3] = '{0, 16, 8'h20, 24, 16, 0};
    tbl[4] = '{0, 17, 8'h30, 24, 16, 1};
    tbl[5] = '{1, 15, 8'h40, 23, 15, 0};

    rst = 1'b1;
    repeat (3) @(posedge rgmii_clk);
    #1;
    cmp("reset_gnt", int'(gnt), 0);
    cmp("reset_rd", int'(rd), 0);
    cmp("reset_tx_valid", int'(tx_valid), 0);
    cmp("reset_tx_data", int'(tx_data), 0);
    cmp("reset_busy", int'(busy), 0);
    cmp("reset_overrun", int'(overrun), 0);
    rst = 1'b0;
    @(posedge rgmii_clk); #1;

    $display("[TB] grant latency and 1-byte payload");
    load_frame(0, 1, 8'h3C);
    plan_batch();
    @(negedge rgmii_clk);
    @(posedge rgmii_clk); #1;
    cmp("lat_gnt", int'(gnt), 1);
    cmp("lat_busy", int'(busy), 1);
    cmp("lat_tx_valid_before_pre", int'(tx_valid), 0);
    @(posedge rgmii_clk); #1;
    cmp("lat_first_pre_valid", int'(tx_valid), 1);
    cmp("lat_first_pre_byte", int'(tx_data), 8'h55);
    wait_idle(200);
    cmp("one_byte_rd_cycles", last_rd, 1);
    cmp("one_byte_wire_len", last_wire, 9);

    $display("[TB] table vectors");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i]);
    end

    $display("[TB] request during IFG");
    fc = frame_count;
    load_frame(1, 2, 8'h70);
    plan_batch();
    guard = 0;
    while (frame_count <= fc && guard < 200) begin
      @(posedge rgmii_clk); #1;
      guard++;
    end
    cmp("ifg_first_frame_seen", (frame_count > fc) ? 1 : 0, 1);
    s1 = last_start;
    @(posedge rgmii_clk); #1;
    cmp("ifg_still_busy", int'(busy), 1);
    load_frame(0, 3, 8'h80);
    plan_batch();
    wait_idle(300);
    cmp("ifg_gap_cycles", last_gap, IFG_BYTES + 1);
    cmp("ifg_frame_spacing", last_start - s1, PRE_LEN + 1 + 2 + IFG_BYTES + 1);

    $display("[TB] reset during payload");
    load_frame(0, 10, 8'h60);
    plan_batch();
    guard = 0;
    while (rd_cyc < 2 && guard < 200) begin
      @(posedge rgmii_clk); #1;
      guard++;
    end
    cmp("rst_reached_payload", (rd_cyc >= 2) ? 1 : 0, 1);
    rst = 1'b1;
    mdl_last = 1;
    @(posedge rgmii_clk); #1;
    cmp("rst_mid_tx_valid", int'(tx_valid), 0);
    cmp("rst_mid_gnt", int'(gnt), 0);
    cmp("rst_mid_busy", int'(busy), 0);
    cmp("rst_mid_rd", int'(rd), 0);
    cmp("rst_mid_overrun", int'(overrun), 0);
    rst = 1'b0;
    @(posedge rgmii_clk); #1;

    $display("[TB] round-robin with both requests held");
    n0 = src_log.size();
    for (int i = 0; i < 3; i++) begin
      load_frame(0, 2, 8'(8'h90 + 8'(i * 16)));
      load_frame(1, 2, 8'(8'hC0 + 8'(i * 16)));
    end
    plan_batch();
    wait_idle(800);
    cmp("rr_frame_count", src_log.size() - n0, 6);
    if (src_log.size() >= n0 + 6)
      for (int i = 0; i < 6; i++) cmp("rr_grant_src", src_log[n0 + i], i % 2);

    $display("[TB] randomized batches");
    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < 2; s++) begin
        k = $urandom_range(0, 3);
        for (int j = 0; j < k; j++) load_frame(s, $urandom_range(1, 20), 8'($urandom));
      end
      plan_batch();
      wait_idle(2000);
      repeat ($urandom_range(0, 5)) @(posedge rgmii_clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
